// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase select types used by the response path.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        DSEL_S1,
        DSEL_S2,
        DSEL_S3,
        DSEL_S4,
        DSEL_DEF,
        DSEL_NONE
    } dsel_e;

    typedef enum logic [1:0] {
        IDLE,
        ERR1,
        ERR2
    } dslv_state_e;

    // Anything but a clean one-hot select becomes the default slave on an active
    // transfer, or no slave at all when the master is idle/busy.
    function automatic dsel_e decode_sel(input logic [3:0] hsel, input logic [1:0] htrans);
        dsel_e sel;
        case (hsel)
            4'b0001: sel = DSEL_S1;
            4'b0010: sel = DSEL_S2;
            4'b0100: sel = DSEL_S3;
            4'b1000: sel = DSEL_S4;
            default: sel = (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) ? DSEL_DEF : DSEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped/invalid active transfers with the two-cycle AHB ERROR response.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic start,
    output logic ready,
    output logic resp
);

    dslv_state_e state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ERR1;
            ERR1:    state_d = ERR2;
            ERR2:    state_d = start ? ERR1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        resp  = HRESP_OKAY;
        case (state_q)
            ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            ERR2: begin
                ready = 1'b1;
                resp  = HRESP_ERROR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response path: registers the address-phase select and routes the data-phase
// slave response back to the master, with a default slave and a wait-state timeout monitor.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel_1,
    input  logic              hsel_2,
    input  logic              hsel_3,
    input  logic              hsel_4,
    input  logic [1:0]        htrans,
    input  logic [DATA_W-1:0] hrdata_1,
    input  logic [DATA_W-1:0] hrdata_2,
    input  logic [DATA_W-1:0] hrdata_3,
    input  logic [DATA_W-1:0] hrdata_4,
    input  logic              hreadyout_1,
    input  logic              hreadyout_2,
    input  logic              hreadyout_3,
    input  logic              hreadyout_4,
    input  logic              hresp_1,
    input  logic              hresp_2,
    input  logic              hresp_3,
    input  logic              hresp_4,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic              hresp,
    output logic              timeout_err
);

    localparam int              CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    dsel_e            dsel_q, dsel_d, addr_sel;
    logic             def_start, def_ready, def_resp;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    assign addr_sel  = decode_sel({hsel_4, hsel_3, hsel_2, hsel_1}, htrans);
    assign def_start = hready && (addr_sel == DSEL_DEF);

    // The data-phase owner only advances when the current data phase completes.
    assign dsel_d = hready ? addr_sel : dsel_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q        <= DSEL_NONE;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            dsel_q        <= dsel_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    ahb_default_slave u_default_slave (
        .hclk    (hclk),
        .hresetn (hresetn),
        .start   (def_start),
        .ready   (def_ready),
        .resp    (def_resp)
    );

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (dsel_q)
            DSEL_S1: begin
                hrdata = hrdata_1;
                hready = hreadyout_1;
                hresp  = hresp_1;
            end
            DSEL_S2: begin
                hrdata = hrdata_2;
                hready = hreadyout_2;
                hresp  = hresp_2;
            end
            DSEL_S3: begin
                hrdata = hrdata_3;
                hready = hreadyout_3;
                hresp  = hresp_3;
            end
            DSEL_S4: begin
                hrdata = hrdata_4;
                hready = hreadyout_4;
                hresp  = hresp_4;
            end
            DSEL_DEF: begin
                hready = def_ready;
                hresp  = def_resp;
            end
            default: ;
        endcase
    end

    // Counter saturates at TIMEOUT_CYC; the error flag is sticky until reset.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        if (TIMEOUT_CYC != 0) begin
            if (hready) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            if (!hready && wait_cnt_d == CNT_MAX) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: directed scenarios plus random traffic against a transfer-level model.
module tb_ahb_resp_mux;

    localparam int DATA_W = 32;
    localparam int TCYC   = 4;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic [3:0]        sel;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] rd [4];
    logic [3:0]        rdy;
    logic [3:0]        rsp;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    // Transfer-level model: who owns the data phase, which error cycle the default
    // slave is in, how long the bus has been stalled, and the sticky timeout flag.
    int m_owner;
    int m_err_cycle;
    int m_stall;
    bit m_tout;

    always #5 hclk = ~hclk;

    ahb_resp_mux #(.DATA_W(DATA_W), .TIMEOUT_CYC(TCYC)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel_1      (sel[0]),
        .hsel_2      (sel[1]),
        .hsel_3      (sel[2]),
        .hsel_4      (sel[3]),
        .htrans      (htrans),
        .hrdata_1    (rd[0]),
        .hrdata_2    (rd[1]),
        .hrdata_3    (rd[2]),
        .hrdata_4    (rd[3]),
        .hreadyout_1 (rdy[0]),
        .hreadyout_2 (rdy[1]),
        .hreadyout_3 (rdy[2]),
        .hreadyout_4 (rdy[3]),
        .hresp_1     (rsp[0]),
        .hresp_2     (rsp[1]),
        .hresp_3     (rsp[2]),
        .hresp_4     (rsp[3]),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rdata();
        if (m_owner >= 1 && m_owner <= 4) return rd[m_owner-1];
        return '0;
    endfunction

    function automatic logic exp_ready();
        if (m_owner >= 1 && m_owner <= 4) return rdy[m_owner-1];
        if (m_owner == 5) return (m_err_cycle == 2);
        return 1'b1;
    endfunction

    function automatic logic exp_resp();
        if (m_owner >= 1 && m_owner <= 4) return rsp[m_owner-1];
        return (m_owner == 5);
    endfunction

    task automatic check_outputs(input string tag);
        #1;
        check({tag, ".hrdata"}, 64'(hrdata), 64'(exp_rdata()));
        check({tag, ".hready"}, 64'(hready), 64'(exp_ready()));
        check({tag, ".hresp"},  64'(hresp),  64'(exp_resp()));
        check({tag, ".tout"},   64'(timeout_err), 64'(m_tout));
    endtask

    // Advance the model by one clock edge, then the DUT.
    task automatic edge_step();
        logic hr;
        int   n;
        int   idx;
        hr = exp_ready();
        if (hr) begin
            n   = 0;
            idx = 0;
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) begin
                    n++;
                    idx = k + 1;
                end
            end
            if (n == 1)         m_owner = idx;
            else if (htrans[1]) m_owner = 5;
            else                m_owner = 0;
            m_err_cycle = (m_owner == 5) ? 1 : 0;
        end else if (m_owner == 5) begin
            m_err_cycle = 2;
        end
        m_stall = hr ? 0 : m_stall + 1;
        if (TCYC != 0 && m_stall >= TCYC) m_tout = 1'b1;
        @(posedge hclk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        hresetn = 1'b0;
        #1;
        m_owner     = 0;
        m_err_cycle = 0;
        m_stall     = 0;
        m_tout      = 1'b0;
        check({tag, ".hready"}, 64'(hready), 64'(1));
        check({tag, ".hresp"},  64'(hresp),  64'(0));
        check({tag, ".hrdata"}, 64'(hrdata), 64'(0));
        check({tag, ".tout"},   64'(timeout_err), 64'(0));
        hresetn = 1'b1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [1:0] t);
        sel    = s;
        htrans = t;
    endtask

    initial begin
        hresetn = 1'b0;
        sel     = '0;
        htrans  = 2'b00;
        rdy     = '1;
        rsp     = '0;
        for (int k = 0; k < 4; k++) rd[k] = 32'hDEAD_0000 | 32'(k + 1);
        @(posedge hclk);
        #1;
        apply_reset("reset0");

        // Slave 3 read with two wait states.
        drive(4'b0100, 2'b10);
        check_outputs("s3_addr");
        edge_step();
        drive(4'b0000, 2'b00);
        rd[2]  = 32'hA5A5_0003;
        rdy[2] = 1'b0;
        check_outputs("s3_wait1");
        check("s3_wait1_lit", 64'(hready), 64'(0));
        edge_step();
        check_outputs("s3_wait2");
        edge_step();
        rdy[2] = 1'b1;
        check_outputs("s3_done");
        check("s3_done_lit", 64'(hrdata), 64'(32'hA5A5_0003));
        edge_step();

        // Pipelined slave 2 then slave 4, with the idle slave holding hreadyout low.
        drive(4'b0010, 2'b10);
        check_outputs("pipe_a2");
        edge_step();
        drive(4'b1000, 2'b11);
        rd[1]  = 32'h2222_0002;
        rdy[3] = 1'b0;
        check_outputs("pipe_d2");
        check("pipe_d2_lit", 64'(hrdata), 64'(32'h2222_0002));
        edge_step();
        drive(4'b0000, 2'b00);
        rd[3]  = 32'h4444_0004;
        rdy[1] = 1'b0;
        rdy[3] = 1'b1;
        check_outputs("pipe_d4");
        check("pipe_d4_lit", 64'(hrdata), 64'(32'h4444_0004));
        edge_step();
        rdy = '1;

        // Default slave: no select, then two selects, each on an active transfer.
        for (int v = 0; v < 2; v++) begin
            drive(v == 0 ? 4'b0000 : 4'b0011, 2'b10);
            check_outputs("def_addr");
            edge_step();
            drive(4'b0000, 2'b00);
            check_outputs("def_c1");
            check("def_c1_lit", 64'({hready, hresp}), 64'(2'b01));
            edge_step();
            check_outputs("def_c2");
            check("def_c2_lit", 64'({hready, hresp}), 64'(2'b11));
            edge_step();
            check_outputs("def_ok");
            check("def_ok_lit", 64'({hready, hresp}), 64'(2'b10));
        end

        // Idle transfer with no select yields a zero-wait OKAY with zero data.
        drive(4'b0000, 2'b00);
        edge_step();
        check_outputs("idle");
        check("idle_lit", 64'({hrdata, hready, hresp}), 64'({32'h0, 1'b1, 1'b0}));

        // Timeout: slave 1 stalls TCYC cycles, flag sets on the last of them and sticks.
        drive(4'b0001, 2'b10);
        edge_step();
        drive(4'b0000, 2'b00);
        rdy[0] = 1'b0;
        for (int c = 1; c <= TCYC; c++) begin
            edge_step();
            check_outputs("tout_wait");
            check("tout_lit", 64'(timeout_err), 64'(c == TCYC));
        end
        rdy[0] = 1'b1;
        edge_step();
        edge_step();
        check_outputs("tout_sticky");
        check("tout_sticky_lit", 64'(timeout_err), 64'(1));

        // Reset in the middle of a stalled transfer.
        drive(4'b0001, 2'b10);
        edge_step();
        drive(4'b0000, 2'b00);
        rdy[0] = 1'b0;
        edge_step();
        apply_reset("reset_mid");
        rdy[0] = 1'b1;
        edge_step();
        check_outputs("post_reset");

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 6) sel = 4'(1 << $urandom_range(0, 3));
            else                          sel = 4'($urandom_range(0, 15));
            htrans = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                rd[k]  = $urandom;
                rdy[k] = ($urandom_range(0, 3) != 0);
                rsp[k] = ($urandom_range(0, 7) == 0);
            end
            if (i % 150 == 149) apply_reset("rand_reset");
            check_outputs("rand");
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
